// File: rtl/alu_muldiv_if.sv
// Handshake and data bundle between the execute stage and the iterative mul/div unit.
// The master side issues operations and consumes results; the slave side is the unit.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Z;
  logic             NEG;

  modport master (
    output in_valid, op, a_in, b_in, out_ready,
    input  in_ready, out_valid, ALUResult, Z, NEG
  );

  modport slave (
    input  in_valid, op, a_in, b_in, out_ready,
    output in_ready, out_valid, ALUResult, Z, NEG
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on sign-stripped magnitudes,
// then a single fix-up cycle that restores signs and selects the requested word.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         kill,
  alu_muldiv_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    counter_q, counter_d;
  logic [2:0]       op_q, op_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             z_q, z_d;
  logic             neg_q, neg_d;

  logic             op_is_div;
  logic             a_signed, b_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept;
  logic             div_by_zero, div_overflow, fast_path;
  logic [WIDTH-1:0] fast_result;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_shift, div_diff;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] fix_result;

  // Operand decode on the live inputs; only used in the accept cycle.
  assign op_is_div = bus.op[2];
  assign a_signed  = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                     (bus.op == 3'b100) || (bus.op == 3'b110);
  assign b_signed  = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
  assign a_neg     = a_signed & bus.a_in[WIDTH-1];
  assign b_neg     = b_signed & bus.b_in[WIDTH-1];
  assign a_mag     = a_neg ? (~bus.a_in + WIDTH'(1)) : bus.a_in;
  assign b_mag     = b_neg ? (~bus.b_in + WIDTH'(1)) : bus.b_in;
  assign accept    = (state_q == IDLE) && bus.in_valid && !kill;

  assign div_by_zero  = op_is_div && (bus.b_in == '0);
  assign div_overflow = ((bus.op == 3'b100) || (bus.op == 3'b110)) &&
                        (bus.a_in == MIN_NEG) && (bus.b_in == '1);
  assign fast_path    = div_by_zero || div_overflow;

  // op[1] separates REM/REMU from DIV/DIVU within the divide group.
  always_comb begin
    fast_result = '0;
    if (div_by_zero) begin
      fast_result = bus.op[1] ? bus.a_in : '1;
    end else if (div_overflow) begin
      fast_result = bus.op[1] ? '0 : bus.a_in;
    end
  end

  // Per-cycle iteration arithmetic: shift-add multiply and restoring divide.
  assign mul_sum   = {1'b0, prod_q[PW-1:WIDTH]} + {1'b0, opb_q};
  assign div_shift = {rem_q, prod_q[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, opb_q};

  // Quotient sits in the low word with a zero high word, so one wide negate serves both.
  assign prod_fix = neg_res_q ? (~prod_q + PW'(1)) : prod_q;
  assign rem_fix  = neg_rem_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];

  always_comb begin
    fix_result = prod_fix[PW-1:WIDTH];
    case (op_q)
      3'b000, 3'b100, 3'b101: fix_result = prod_fix[WIDTH-1:0];
      3'b110, 3'b111:         fix_result = rem_fix;
      default:                fix_result = prod_fix[PW-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      counter_q <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opb_q     <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      z_q       <= 1'b1;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opb_q     <= opb_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      z_q       <= z_d;
      neg_q     <= neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fast_path ? DONE : CALC;
      CALC: if (counter_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // Datapath; a kill during FIX must leave the visible result untouched.
  always_comb begin
    counter_d = counter_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opb_d     = opb_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    result_d  = result_q;
    z_d       = z_q;
    neg_d     = neg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = bus.op;
          counter_d = CW'(WIDTH - 1);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          rem_d     = '0;
          if (op_is_div) begin
            opb_d  = b_mag;
            prod_d = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opb_d  = a_mag;
            prod_d = {{WIDTH{1'b0}}, b_mag};
          end
          if (fast_path) begin
            result_d = fast_result;
            z_d      = (fast_result == '0);
            neg_d    = fast_result[WIDTH-1];
          end
        end
      end
      CALC: begin
        if (counter_q != '0) counter_d = counter_q - CW'(1);
        if (op_q[2]) begin
          if (!div_diff[WIDTH+1]) begin
            rem_d  = div_diff[WIDTH:0];
            prod_d = {prod_q[PW-1:WIDTH], prod_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = div_shift[WIDTH:0];
            prod_d = {prod_q[PW-1:WIDTH], prod_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          prod_d = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[PW-1:1]};
        end
      end
      FIX: begin
        if (!kill) begin
          result_d = fix_result;
          z_d      = (fix_result == '0);
          neg_d    = fix_result[WIDTH-1];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.ALUResult = result_q;
    bus.Z         = z_q;
    bus.NEG       = neg_q;
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv: results, flags, latency, backpressure,
// kill and asynchronous reset, all against hand-computed RV32M values.
module tb_alu_muldiv;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic clk;
  logic resetn;
  logic kill;
  int   vectorCount;
  int   missCount;

  alu_muldiv_if #(.WIDTH(32)) bus ();

  alu_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .kill   (kill),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One full transaction: issue, time to out_valid, optional hold-off, then consume.
  task automatic applyStimulus(input string name, input logic [2:0] opc,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input int expLat,
                               input int holdCycles);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = opc;
    bus.a_in     = a;
    bus.b_in     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.a_in     = $urandom;
    bus.b_in     = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
    for (int i = 0; i < holdCycles; i++) begin
      checkOutput({name, " held result"}, bus.ALUResult, expRes);
      checkOutput({name, " held in_ready"}, {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput({name, " out_valid"}, {31'b0, bus.out_valid}, 32'd1);
    checkOutput({name, " result"}, bus.ALUResult, expRes);
    checkOutput({name, " Z"}, {31'b0, bus.Z}, {31'b0, (expRes == 32'd0)});
    checkOutput({name, " NEG"}, {31'b0, bus.NEG}, {31'b0, expRes[31]});
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({name, " released out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    checkOutput({name, " released in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    checkOutput({name, " idle hold"}, bus.ALUResult, expRes);
  endtask

  initial begin
    int sawValid;
    vectorCount   = 0;
    missCount     = 0;
    resetn        = 1'b0;
    kill          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = OP_MUL;
    bus.a_in      = '0;
    bus.b_in      = '0;

    #22;
    checkOutput("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("reset ALUResult", bus.ALUResult, 32'd0);
    checkOutput("reset Z", {31'b0, bus.Z}, 32'd1);
    checkOutput("reset NEG", {31'b0, bus.NEG}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    applyStimulus("MUL 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    applyStimulus("MUL shift", OP_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 34, 0);
    applyStimulus("MULH min*min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    applyStimulus("MULH -3*5", OP_MULH, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 34, 0);
    applyStimulus("MULHU", OP_MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    applyStimulus("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 0);
    applyStimulus("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    applyStimulus("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    applyStimulus("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0);
    applyStimulus("REM 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);
    applyStimulus("DIVU max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0);
    applyStimulus("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 34, 0);
    applyStimulus("DIVU by 0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    applyStimulus("REM by 0", OP_REM, 32'd5, 32'd0, 32'd5, 1, 0);
    applyStimulus("DIV overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    applyStimulus("REM overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

    applyStimulus("DIVU backpressure", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 10);
    applyStimulus("MUL back-to-back", OP_MUL, 32'd9, 32'd9, 32'd81, 34, 0);

    // A kill coinciding with in_valid in IDLE must not start an operation.
    @(negedge clk);
    kill         = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.a_in     = 32'd2;
    bus.b_in     = 32'd2;
    @(posedge clk);
    #1;
    kill         = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("kill+in_valid in_ready", {31'b0, bus.in_ready}, 32'd1);
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid++;
    end
    checkOutput("kill+in_valid no result", 32'(sawValid), 32'd0);

    // Kill partway through CALC; the aborted product must never appear.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.a_in     = 32'd5;
    bus.b_in     = 32'd6;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    checkOutput("kill out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("kill in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("kill result held", bus.ALUResult, 32'd81);
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid++;
    end
    checkOutput("killed op no result", 32'(sawValid), 32'd0);
    applyStimulus("MUL 3*4 after kill", OP_MUL, 32'd3, 32'd4, 32'd12, 34, 0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = OP_DIV;
    bus.a_in     = 32'hFFFF_FFF9;
    bus.b_in     = 32'd2;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("async reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("async reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("async reset ALUResult", bus.ALUResult, 32'd0);
    checkOutput("async reset Z", {31'b0, bus.Z}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid++;
    end
    checkOutput("reset op no result", 32'(sawValid), 32'd0);
    applyStimulus("DIVU after reset", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
